// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped, write-through, one-word-line data cache that
//            serves LSQ loads and retired stores. Load misses are tracked in
//            an MSHR file. A one-entry pending-store register absorbs stores
//            that cannot reach the memory bus in their own cycle.
// Config   : DCACHE_WR_ALLOC_EN - when defined, store misses allocate the line.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
  parameter int IDX_BITS  = 5,
  parameter int MSHR_NUM  = 4,
  parameter int MSHR_BITS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Dcache_rd_mem,
  input  logic [63:0] Dcache_addr,
  input  logic [6:0]  Dcache_pr_idx,
  input  logic [4:0]  Dcache_ar_idx,
  input  logic        Dcache_wr_mem,
  input  logic [63:0] Dcache_st_addr,
  input  logic [63:0] Dcache_st_value,
  output logic        Dcache_avail,
  output logic        cdb_complete,
  output logic [6:0]  cdb_prf_pr_idx,
  output logic [4:0]  cdb_ar_idx,
  output logic        prf_pr_wr_enable,
  output logic [63:0] prf_pr_value,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag
);

  localparam int         c_LINES        = 1 << IDX_BITS;
  localparam int         c_TAG_W        = 64 - IDX_BITS - 3;
  localparam logic [1:0] c_BUS_NONE     = 2'd0;
  localparam logic [1:0] c_BUS_LOAD     = 2'd1;
  localparam logic [1:0] c_BUS_STORE    = 2'd2;
  localparam logic [1:0] c_MSHR_INVALID = 2'd0;
  localparam logic [1:0] c_MSHR_ISSUE   = 2'd1;
  localparam logic [1:0] c_MSHR_WAIT    = 2'd2;

  // Cache array
  logic [c_LINES-1:0] r_line_valid;
  logic [c_TAG_W-1:0] r_line_tag  [c_LINES];
  logic [63:0]        r_line_data [c_LINES];

  // MSHR file
  logic [1:0]          r_mshr_state [MSHR_NUM];
  logic [1:0]          w_mshr_state_nxt [MSHR_NUM];
  logic [63:0]         r_mshr_addr  [MSHR_NUM];
  logic [6:0]          r_mshr_pr    [MSHR_NUM];
  logic [4:0]          r_mshr_ar    [MSHR_NUM];
  logic [3:0]          r_mshr_tag   [MSHR_NUM];
  logic [MSHR_NUM-1:0] r_mshr_sup;   // a store hit this index while waiting: drop the fill write

  // Pending store
  logic        r_pst_valid;
  logic [63:0] r_pst_addr;
  logic [63:0] r_pst_value;

  // CDB result
  logic        r_cdb_complete;
  logic [6:0]  r_cdb_pr;
  logic [4:0]  r_cdb_ar;
  logic [63:0] r_cdb_value;

  logic [IDX_BITS-1:0] w_ld_idx, w_st_idx, w_fill_idx;
  logic [c_TAG_W-1:0]  w_ld_tag, w_st_tag, w_fill_tag;
  logic                w_ld_hit, w_st_hit;
  logic                w_fill_hit, w_fill_wr, w_st_wr;
  logic [MSHR_BITS-1:0] w_fill_sel, w_free_sel, w_iss_sel;
  logic                w_mshr_full, w_iss_valid;
  logic                w_ld_acc, w_alloc, w_hit_acc;
  logic [63:0]         w_iss_addr;
  logic [1:0]          w_bus_cmd;
  logic [63:0]         w_bus_addr, w_bus_data;
  logic                w_granted, w_ld_grant, w_st_grant;
  logic                w_unused;

  assign w_ld_idx   = Dcache_addr[IDX_BITS+2:3];
  assign w_ld_tag   = Dcache_addr[63:IDX_BITS+3];
  assign w_st_idx   = Dcache_st_addr[IDX_BITS+2:3];
  assign w_st_tag   = Dcache_st_addr[63:IDX_BITS+3];
  assign w_ld_hit   = r_line_valid[w_ld_idx] && (r_line_tag[w_ld_idx] == w_ld_tag);
  assign w_st_hit   = r_line_valid[w_st_idx] && (r_line_tag[w_st_idx] == w_st_tag);
  assign w_fill_idx = r_mshr_addr[w_fill_sel][IDX_BITS+2:3];
  assign w_fill_tag = r_mshr_addr[w_fill_sel][63:IDX_BITS+3];

  // Lowest free MSHR and full flag
  always_comb begin
    w_mshr_full = 1'b1;
    w_free_sel  = '0;
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      if (r_mshr_state[i] == c_MSHR_INVALID) begin
        w_mshr_full = 1'b0;
        w_free_sel  = MSHR_BITS'(i);
      end
    end
  end

  // Returning memory tag matched against waiting MSHRs
  always_comb begin
    w_fill_hit = 1'b0;
    w_fill_sel = '0;
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      if (r_mshr_state[i] == c_MSHR_WAIT && mem2proc_tag != 4'd0 &&
          r_mshr_tag[i] == mem2proc_tag) begin
        w_fill_hit = 1'b1;
        w_fill_sel = MSHR_BITS'(i);
      end
    end
  end

  // A fill owns next cycle's CDB slot, so no load is accepted alongside it
  assign Dcache_avail = ~w_mshr_full & ~r_pst_valid & ~w_fill_hit;
  assign w_ld_acc     = Dcache_rd_mem & Dcache_avail;
  assign w_alloc      = w_ld_acc & ~w_ld_hit;
  assign w_hit_acc    = w_ld_acc & w_ld_hit;

  // Lowest ISSUE entry, counting an allocation made this cycle
  always_comb begin
    w_iss_valid = 1'b0;
    w_iss_sel   = '0;
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      if (r_mshr_state[i] == c_MSHR_ISSUE || (w_alloc && w_free_sel == MSHR_BITS'(i))) begin
        w_iss_valid = 1'b1;
        w_iss_sel   = MSHR_BITS'(i);
      end
    end
  end

  assign w_iss_addr = (w_alloc && w_iss_sel == w_free_sel) ? Dcache_addr : r_mshr_addr[w_iss_sel];

  // Bus arbitration: pending store, incoming store, then load misses
  always_comb begin
    w_bus_cmd  = c_BUS_NONE;
    w_bus_addr = '0;
    w_bus_data = '0;
    if (reset) begin
      if (r_pst_valid) begin
        w_bus_cmd  = c_BUS_STORE;
        w_bus_addr = r_pst_addr;
        w_bus_data = r_pst_value;
      end else if (Dcache_wr_mem) begin
        w_bus_cmd  = c_BUS_STORE;
        w_bus_addr = Dcache_st_addr;
        w_bus_data = Dcache_st_value;
      end else if (w_iss_valid) begin
        w_bus_cmd  = c_BUS_LOAD;
        w_bus_addr = w_iss_addr;
      end
    end
  end

  assign w_granted        = |mem2proc_response;
  assign w_ld_grant       = (w_bus_cmd == c_BUS_LOAD) & w_granted;
  assign w_st_grant       = (w_bus_cmd == c_BUS_STORE) & w_granted;
  assign proc2mem_command = w_bus_cmd;
  assign proc2mem_addr    = {w_bus_addr[63:3], 3'b000};
  assign proc2mem_data    = w_bus_data;
  assign w_unused         = ^w_bus_addr[2:0];

`ifdef DCACHE_WR_ALLOC_EN
  assign w_st_wr = Dcache_wr_mem;
`else
  assign w_st_wr = Dcache_wr_mem & w_st_hit;
`endif

  // A store to the same index in the fill cycle also wins over the fill
  assign w_fill_wr = w_fill_hit & ~r_mshr_sup[w_fill_sel] &
                     ~(Dcache_wr_mem && w_st_idx == w_fill_idx);

  // MSHR next state
  always_comb begin
    for (int i = 0; i < MSHR_NUM; i++) begin
      w_mshr_state_nxt[i] = r_mshr_state[i];
      case (r_mshr_state[i])
        c_MSHR_INVALID:
          if (w_alloc && w_free_sel == MSHR_BITS'(i))
            w_mshr_state_nxt[i] = (w_ld_grant && w_iss_sel == MSHR_BITS'(i)) ? c_MSHR_WAIT : c_MSHR_ISSUE;
        c_MSHR_ISSUE:
          if (w_ld_grant && w_iss_sel == MSHR_BITS'(i))
            w_mshr_state_nxt[i] = c_MSHR_WAIT;
        c_MSHR_WAIT:
          if (w_fill_hit && w_fill_sel == MSHR_BITS'(i))
            w_mshr_state_nxt[i] = c_MSHR_INVALID;
        default:
          w_mshr_state_nxt[i] = c_MSHR_INVALID;
      endcase
    end
  end

  // MSHR state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSHR_NUM; i++) r_mshr_state[i] <= c_MSHR_INVALID;
    end else begin
      for (int i = 0; i < MSHR_NUM; i++) r_mshr_state[i] <= w_mshr_state_nxt[i];
    end
  end

  // MSHR payload: request capture, bus tag latch, store-collision flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mshr_sup <= '0;
      for (int i = 0; i < MSHR_NUM; i++) begin
        r_mshr_addr[i] <= '0;
        r_mshr_pr[i]   <= '0;
        r_mshr_ar[i]   <= '0;
        r_mshr_tag[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < MSHR_NUM; i++) begin
        if (w_alloc && w_free_sel == MSHR_BITS'(i)) begin
          r_mshr_addr[i] <= Dcache_addr;
          r_mshr_pr[i]   <= Dcache_pr_idx;
          r_mshr_ar[i]   <= Dcache_ar_idx;
          r_mshr_sup[i]  <= 1'b0;
        end else if (r_mshr_state[i] == c_MSHR_WAIT && Dcache_wr_mem &&
                     w_st_idx == r_mshr_addr[i][IDX_BITS+2:3]) begin
          r_mshr_sup[i]  <= 1'b1;
        end
        if (w_ld_grant && w_iss_sel == MSHR_BITS'(i))
          r_mshr_tag[i] <= mem2proc_response;
      end
    end
  end

  // Line valid bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_line_valid <= '0;
    end else begin
      if (w_fill_wr) r_line_valid[w_fill_idx] <= 1'b1;
      if (w_st_wr)   r_line_valid[w_st_idx]   <= 1'b1;
    end
  end

  // Line tag and data; fill and store never target the same index together
  always_ff @(posedge clock) begin
    if (w_fill_wr) begin
      r_line_tag[w_fill_idx]  <= w_fill_tag;
      r_line_data[w_fill_idx] <= mem2proc_data;
    end
    if (w_st_wr) begin
      r_line_tag[w_st_idx]  <= w_st_tag;
      r_line_data[w_st_idx] <= Dcache_st_value;
    end
  end

  // Pending-store register: holds a store that was rejected or lost arbitration
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pst_valid <= 1'b0;
      r_pst_addr  <= '0;
      r_pst_value <= '0;
    end else if (r_pst_valid) begin
      if (w_st_grant) begin
        r_pst_valid <= Dcache_wr_mem;
        r_pst_addr  <= Dcache_st_addr;
        r_pst_value <= Dcache_st_value;
      end
    end else if (Dcache_wr_mem && !w_st_grant) begin
      r_pst_valid <= 1'b1;
      r_pst_addr  <= Dcache_st_addr;
      r_pst_value <= Dcache_st_value;
    end
  end

  // CDB result register: fill data or hit data (old array value)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cdb_complete <= 1'b0;
      r_cdb_pr       <= '0;
      r_cdb_ar       <= '0;
      r_cdb_value    <= '0;
    end else begin
      r_cdb_complete <= w_fill_hit | w_hit_acc;
      r_cdb_pr       <= '0;
      r_cdb_ar       <= '0;
      r_cdb_value    <= '0;
      if (w_fill_hit) begin
        r_cdb_pr    <= r_mshr_pr[w_fill_sel];
        r_cdb_ar    <= r_mshr_ar[w_fill_sel];
        r_cdb_value <= mem2proc_data;
      end else if (w_hit_acc) begin
        r_cdb_pr    <= Dcache_pr_idx;
        r_cdb_ar    <= Dcache_ar_idx;
        r_cdb_value <= r_line_data[w_ld_idx];
      end
    end
  end

  assign cdb_complete     = r_cdb_complete;
  assign cdb_prf_pr_idx   = r_cdb_pr;
  assign cdb_ar_idx       = r_cdb_ar;
  assign prf_pr_wr_enable = r_cdb_complete;
  assign prf_pr_value     = r_cdb_value;

endmodule
`default_nettype wire
